// File: rtl/config_word_loader.sv
// Configuration word loader: deserializes handshake words into a shadow
// register and commits them atomically onto config_out.
module config_word_loader #(
    parameter int CONFIG_WIDTH = 24,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic [WORD_WIDTH-1:0]   chain_out,
    output logic                    chain_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int NUM_WORDS =
        (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int SHADOW_WIDTH = NUM_WORDS * WORD_WIDTH;
    localparam int COUNT_WIDTH  = $clog2(NUM_WORDS + 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_BEAT =
        COUNT_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [SHADOW_WIDTH-1:0] shadow;
    logic [COUNT_WIDTH-1:0]  word_count;
    logic                    accept;
    logic                    last_beat;

    // A restart pulse in LOAD wins over a word offered in the same cycle.
    always_comb begin
        accept     = (state == LOAD) && word_valid && !start;
        last_beat  = accept && (word_count == LAST_BEAT);
        word_ready = (state == LOAD);
        busy       = (state == LOAD) || (state == COMMIT);
        done       = (state == DONE);
    end

    // State register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; COMMIT always runs to completion.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                if (last_beat) state_next = COMMIT;
            end
            COMMIT: begin
                state_next = DONE;
            end
            DONE: begin
                if (start) state_next = LOAD;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift words into the shadow, feed the chain, commit in one cycle.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            shadow      <= '0;
            word_count  <= '0;
            config_out  <= '0;
            chain_out   <= '0;
            chain_valid <= 1'b0;
        end else begin
            chain_valid <= accept;
            if (accept) begin
                shadow     <= SHADOW_WIDTH'({shadow, word_in});
                chain_out  <= shadow[SHADOW_WIDTH-1 -: WORD_WIDTH];
                word_count <= word_count + 1'b1;
            end
            if (start && (state != COMMIT)) begin
                word_count <= '0;
            end
            if (state == COMMIT) begin
                config_out <= shadow[CONFIG_WIDTH-1:0];
            end
        end
    end

endmodule
